// File: rtl/hbif_uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM and a
// single-entry valid/ready holding register with frame-error and overrun pulses.
module hbif_uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       uart_rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            rx_meta, rx_sync, rx_prev;
  logic            byte_done;

  // rx_prev keeps tracking while disabled, so a line already low when en_i
  // rises never looks like a falling edge.
  assign byte_done = en_i && (state == STOP) && (cnt == LAST) && rx_sync;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      rx_prev     <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      data_o      <= 8'h00;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      rx_meta     <= uart_rx_i;
      rx_sync     <= rx_meta;
      rx_prev     <= rx_sync;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;

      // Holding register: a same-edge handshake frees the slot for the new byte.
      if (byte_done) begin
        if (!valid_o || ready_i) begin
          data_o  <= shift;
          valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end

      if (!en_i) begin
        state   <= IDLE;
        cnt     <= '0;
        bit_idx <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rx_prev && !rx_sync) begin
              state <= START;
              cnt   <= '0;
            end
          end
          START: begin
            if (cnt == HALF) begin
              cnt     <= '0;
              bit_idx <= '0;
              state   <= rx_sync ? IDLE : DATA;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DATA: begin
            if (cnt == LAST) begin
              cnt     <= '0;
              shift   <= {rx_sync, shift[7:1]};
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) state <= STOP;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          STOP: begin
            if (cnt == LAST) begin
              cnt <= '0;
              if (rx_sync) begin
                state <= IDLE;
              end else begin
                frame_err_o <= 1'b1;
                state       <= WAIT_IDLE;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          WAIT_IDLE: begin
            if (rx_sync) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hbif_uart_rx.sv
// Scoreboard bench for hbif_uart_rx at 16 clocks/bit: stimulus pushes expected
// bytes and event cycles, a negedge monitor pops and compares them.
module tb_hbif_uart_rx;
  localparam int CPB = 16;
  // Start edge to first visible output: 2 sync + 1 edge detect + CPB/2 + 1
  // + 8*CPB data + CPB stop = 156 clocks.
  localparam int LAT = 3 + CPB/2 + 1 + 8*CPB + CPB;

  logic       clk = 1'b0;
  logic       rst_n, en, uart_rx, ready;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, overrun_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] exp_data[$];
  int         exp_rise[$];
  int         exp_ferr[$];
  int         exp_ovr[$];

  hbif_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .uart_rx_i(uart_rx),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready),
    .frame_err_o(frame_err_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents something.
  initial begin
    logic v_prev, f_prev, o_prev;
    v_prev = 1'b0; f_prev = 1'b0; o_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (valid_o && ready) begin
          if (exp_data.size() == 0) note_fail("handshake");
          else chk("data_o", int'(data_o), int'(exp_data.pop_front()));
        end
        if (valid_o && !v_prev) begin
          if (exp_rise.size() == 0) note_fail("valid_rise");
          else chk("valid_rise_cycle", cyc, exp_rise.pop_front());
        end
        if (frame_err_o) begin
          chk("frame_err_width", int'(f_prev), 0);
          if (exp_ferr.size() == 0) note_fail("frame_err");
          else chk("frame_err_cycle", cyc, exp_ferr.pop_front());
        end
        if (overrun_o) begin
          chk("overrun_width", int'(o_prev), 0);
          if (exp_ovr.size() == 0) note_fail("overrun");
          else chk("overrun_cycle", cyc, exp_ovr.pop_front());
        end
      end
      v_prev = rst_n && valid_o;
      f_prev = frame_err_o;
      o_prev = overrun_o;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  // abort: 0 none, 1 drop en_i inside bit 4, 2 pulse rst_n inside bit 4
  task automatic send(input logic [7:0] d, input logic stop_b, input bit push_d,
                      input bit rise, input bit ovr, input bit rdy_pulse,
                      input int abort);
    logic [9:0] fr;
    int c0;
    fr = {stop_b, d, 1'b0};
    @(posedge clk); #1;
    c0 = cyc;
    if (push_d) exp_data.push_back(d);
    if (rise)   exp_rise.push_back(c0 + LAT);
    if (!stop_b) exp_ferr.push_back(c0 + LAT);
    if (ovr)    exp_ovr.push_back(c0 + LAT);
    for (int j = 0; j < 10; j++) begin
      uart_rx = fr[j];
      for (int k = 0; k < CPB; k++) begin
        if (j == 9 && rdy_pulse && k == 11) ready = 1'b1;
        if (j == 9 && rdy_pulse && k == 12) ready = 1'b0;
        if (j == 5 && k == 8 && abort == 1) en = 1'b0;
        if (j == 5 && k == 8 && abort == 2) rst_n = 1'b0;
        if (j == 6 && k == 0 && abort == 2) rst_n = 1'b1;
        @(posedge clk); #1;
      end
    end
    uart_rx = 1'b1;
    if (abort == 1) en = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    ready = 1'b1;
    idle(3);
    ready = 1'b0;
    idle(2);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; uart_rx = 1'b1; ready = 1'b0;
    idle(3);
    chk("reset_data", int'(data_o), 0);
    chk("reset_valid", int'(valid_o), 0);
    chk("reset_frame_err", int'(frame_err_o), 0);
    chk("reset_overrun", int'(overrun_o), 0);
    rst_n = 1'b1;
    idle(20);

    // A5, good stop, held until ready rises
    send(8'hA5, 1'b1, 1, 1, 0, 0, 0);
    idle(5);
    ready = 1'b1;
    idle(1);
    chk("valid_after_handshake", int'(valid_o), 0);
    ready = 1'b0;
    idle(20);

    // 5-cycle glitch on an idle line
    uart_rx = 1'b0;
    idle(5);
    uart_rx = 1'b1;
    idle(40);

    // bad stop bit, then a clean frame
    send(8'h3C, 1'b0, 0, 0, 0, 0, 0);
    idle(CPB);
    send(8'h81, 1'b1, 1, 1, 0, 0, 0);
    idle(5);
    drain();

    // back-to-back with ready low: second byte overruns
    send(8'h11, 1'b1, 1, 1, 0, 0, 0);
    send(8'h22, 1'b1, 0, 0, 1, 0, 0);
    idle(5);
    drain();

    // back-to-back with ready exactly on the second completion edge
    send(8'h11, 1'b1, 1, 1, 0, 0, 0);
    send(8'h22, 1'b1, 1, 0, 0, 1, 0);
    idle(5);
    drain();

    // en_i abort, then a fresh frame
    send(8'hFF, 1'b1, 0, 0, 0, 0, 1);
    idle(20);
    send(8'h5A, 1'b1, 1, 1, 0, 0, 0);
    idle(5);
    drain();

    // en_i rising while the line is already low must not start a frame
    en = 1'b0;
    uart_rx = 1'b0;
    idle(10);
    en = 1'b1;
    idle(30);
    uart_rx = 1'b1;
    idle(40);

    // reset abort, then a fresh frame
    send(8'hFF, 1'b1, 0, 0, 0, 0, 2);
    chk("post_reset_valid", int'(valid_o), 0);
    chk("post_reset_data", int'(data_o), 0);
    idle(20);
    send(8'h5A, 1'b1, 1, 1, 0, 0, 0);
    idle(5);
    drain();
    idle(20);

    chk("unconsumed_bytes", exp_data.size(), 0);
    chk("missing_valid_rises", exp_rise.size(), 0);
    chk("missing_frame_errs", exp_ferr.size(), 0);
    chk("missing_overruns", exp_ovr.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hbif_uart_rx.md
HBIF_UART_RX -- requirements
Module: hbif_uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87: clk cycles per UART bit; legal range 4..4095.
REQ-002 SHALL have port clk_i, input, 1: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port en_i, input, 1: block enable; low aborts any frame in progress.
REQ-005 SHALL have port uart_rx_i, input, 1: asynchronous serial line, idle high.
REQ-006 SHALL have port data_o, output, 8: received byte, valid while valid_o=1.
REQ-007 SHALL have port valid_o, output, 1: holding register contains an unconsumed byte.
REQ-008 SHALL have port ready_i, input, 1: downstream accepts data_o when valid_o=1 and ready_i=1.
REQ-009 SHALL have port frame_err_o, output, 1: one-cycle pulse when a stop bit samples 0.
REQ-010 SHALL have port overrun_o, output, 1: one-cycle pulse when a completed byte is dropped.

Function
REQ-011 SHALL pass uart_rx_i through a 2-flop synchronizer, reset value 1; all decoding uses the synchronized value.
REQ-012 SHALL implement the FSM states IDLE, START, DATA, STOP and WAIT_IDLE, plus a baud counter of width clog2(CLKS_PER_BIT) and a 3-bit bit index.
REQ-013 In IDLE, a synchronized 1->0 transition SHALL move the FSM to START and clear the baud counter.
REQ-014 In START, at count CLKS_PER_BIT/2 (integer divide), the FSM SHALL sample the line.
  - Sample 0: move to DATA and restart the counter.
  - Sample 1: treat as a glitch and return to IDLE with no outputs.
REQ-015 In DATA, the FSM SHALL sample each bit at count CLKS_PER_BIT-1, i.e. mid-bit.
  - Bits shift in LSB first.
  - After bit index 7 the FSM moves to STOP.
REQ-016 In STOP, the FSM SHALL sample at count CLKS_PER_BIT-1.
  - Sample 1: the byte completes and the FSM returns to IDLE.
  - Sample 0: pulse frame_err_o for one cycle, discard the byte, and move to WAIT_IDLE.
REQ-017 WAIT_IDLE SHALL return to IDLE on the first cycle the synchronized line is 1.
REQ-018 A completed byte SHALL load data_o and set valid_o on the cycle after the stop-bit sample.
REQ-019 valid_o SHALL clear on the cycle after a handshake (valid_o=1 and ready_i=1) unless a new byte loads on that same edge.
REQ-020 If a byte completes while valid_o=1 and ready_i=1 on the same edge:
  - The old byte is consumed.
  - The new byte loads into the holding register.
  - valid_o stays 1.
  - overrun_o stays 0.
REQ-021 If a byte completes while valid_o=1 and ready_i=0:
  - overrun_o pulses for one cycle.
  - The new byte is dropped.
  - data_o and valid_o are unchanged.
REQ-022 data_o SHALL remain stable while valid_o=1 and ready_i=0.
REQ-023 When en_i=0, the FSM SHALL be forced to IDLE with counters cleared.
  - The holding register, valid_o and the handshake keep operating.
  - Start detection is suppressed.
REQ-024 When en_i rises while the line is low, the block SHALL wait for a fresh 1->0 edge before starting a frame.
REQ-025 frame_err_o and overrun_o SHALL never be asserted for more than one consecutive cycle per event.

Reset
REQ-026 While rst_ni=0, the block SHALL force the following asynchronously:
  - FSM = IDLE; synchronizer flops = 1; counters = 0.
  - data_o = 8'h00, valid_o = 0, frame_err_o = 0, overrun_o = 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no valid_o, frame_err_o or overrun_o pulse, and the FSM SHALL resume from IDLE after release.
REQ-028 The reset release SHALL be taken synchronously to clk_i by the integrating top level; no internal release synchronizer is required.

Verification (CLKS_PER_BIT=16, en_i=1 unless stated)
REQ-029 SHALL check: send 8'hA5 with a good stop bit and ready_i=0 -> data_o=8'hA5 and valid_o=1 on the cycle after the stop sample; raise ready_i -> valid_o=0 on the next cycle.
REQ-030 SHALL check: 5-cycle low glitch on the idle line -> FSM returns to IDLE; no valid_o, frame_err_o or overrun_o.
REQ-031 SHALL check: send 8'h3C with stop bit = 0 -> one frame_err_o pulse, valid_o stays 0; next frame 8'h81 after the line returns high is received correctly.
REQ-032 SHALL check: send 8'h11 then 8'h22 back-to-back with ready_i=0 -> data_o=8'h11, one overrun_o pulse at the second stop sample.
REQ-033 SHALL check: send 8'h11 then 8'h22 with ready_i=1 exactly on the second completion edge -> data_o=8'h22, valid_o stays 1, no overrun_o.
REQ-034 SHALL check two aborts mid-frame:
  - Drop en_i at bit 4 of 8'hFF -> no outputs; after en_i=1, a fresh frame 8'h5A is received correctly.
  - Assert rst_ni=0 at bit 4 instead -> same result.
